// File: rtl/prg_cache.sv
// prg_cache: direct-mapped, read-only program cache with line fill over a
// request/burst handshake. Tag, valid and data arrays are plain registers.
module prg_cache #(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 3,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       prg_address,
  input  logic              invalidate,
  output logic [DATA_W-1:0] prg_data,
  output logic              p_cache_miss,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]             addr_q;
  logic                    addr_vld;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [DATA_W-1:0]       data_mem [LINES][WORDS];

  logic [TAG_BITS-1:0]     fill_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [OFFSET_BITS-1:0]  fill_cnt;
  logic                    kill;

  logic [TAG_BITS-1:0]     q_tag;
  logic [INDEX_BITS-1:0]   q_idx;
  logic [OFFSET_BITS-1:0]  q_off;
  logic                    hit;
  logic                    start_fill;
  logic                    fill_we;
  logic                    fill_last;

  assign q_tag     = addr_q[31 -: TAG_BITS];
  assign q_idx     = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign q_off     = addr_q[OFFSET_BITS-1:0];
  assign hit       = addr_vld & valid[q_idx] & (tag_mem[q_idx] == q_tag);
  assign prg_data  = data_mem[q_idx][q_off];
  assign mem_addr  = {fill_tag, fill_idx, {OFFSET_BITS{1'b0}}};
  assign fill_we   = (state == FILL) & mem_data_valid;
  assign fill_last = fill_we & (fill_cnt == '1);

  // Fetch address register, sampled every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      addr_vld <= 1'b0;
    end else begin
      addr_q   <= prg_address;
      addr_vld <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; mem_req is simply "in FILL" so a reset
  // drops it asynchronously mid-burst.
  always_comb begin
    state_nxt    = state;
    p_cache_miss = 1'b0;
    mem_req      = 1'b0;
    start_fill   = 1'b0;
    case (state)
      IDLE: begin
        p_cache_miss = addr_vld & ~hit;
        if (addr_vld & ~hit) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        p_cache_miss = 1'b1;
        mem_req      = 1'b1;
        if (fill_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill bookkeeping: target line, word counter and invalidate-during-fill flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_tag <= '0;
      fill_idx <= '0;
      fill_cnt <= '0;
      kill     <= 1'b0;
    end else if (start_fill) begin
      fill_tag <= q_tag;
      fill_idx <= q_idx;
      fill_cnt <= '0;
      kill     <= 1'b0;
    end else begin
      if (fill_we) fill_cnt <= fill_cnt + 1'b1;
      if ((state == FILL) && invalidate) kill <= 1'b1;
    end
  end

  // Valid bits and tags; the later write to valid[fill_idx] overrides the
  // global clear, and still reads invalidate so a coincident pulse wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= '0;
      tag_mem <= '{default: '0};
    end else begin
      if (invalidate) valid <= '0;
      if (fill_last) begin
        tag_mem[fill_idx] <= fill_tag;
        valid[fill_idx]   <= ~(kill | invalidate);
      end
    end
  end

  // Data array, written one word per accepted fill beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_mem <= '{default: '{default: '0}};
    end else if (fill_we) begin
      data_mem[fill_idx][fill_cnt] <= mem_data;
    end
  end

endmodule

// File: tb/tb_prg_cache.sv
// tb_prg_cache: directed table/sequences plus randomized traffic, checked
// against a line-level behavioural model of the cache and a memory pattern.
module tb_prg_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] prg_address = '0;
  logic        invalidate = 1'b0;
  logic [15:0] prg_data;
  logic        p_cache_miss;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  prg_cache #(.INDEX_BITS(4), .OFFSET_BITS(3), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .prg_address(prg_address), .invalidate(invalidate),
    .prg_data(prg_data), .p_cache_miss(p_cache_miss), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory content: 0x1000 + address, with upper half folded in.
  function automatic logic [15:0] fw(input logic [31:0] a);
    return 16'h1000 + a[15:0] + a[31:16] * 16'd7;
  endfunction

  // ---------------- behavioural model (16 lines x 8 words) ----------------
  bit          lv [16];
  logic [24:0] lt [16];
  bit          m_vld;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_kill;
  logic [31:0] m_base;
  int          m_cnt;

  function automatic bit m_hit(input logic [31:0] a);
    return lv[a[6:3]] && (lt[a[6:3]] == a[31:7]);
  endfunction

  task automatic model_reset();
    foreach (lv[i]) lv[i] = 0;
    m_vld = 0; m_addr = '0; m_busy = 0; m_kill = 0; m_base = '0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input bit inv, input bit dv);
    bit was_busy = m_busy;
    bit done = 0;
    if (was_busy) begin
      if (dv) begin
        if (m_cnt == 7) done = 1;
        m_cnt++;
      end
    end else if (m_vld && !m_hit(m_addr)) begin
      m_busy = 1; m_base = {m_addr[31:3], 3'b000}; m_cnt = 0; m_kill = 0;
    end
    if (inv) foreach (lv[i]) lv[i] = 0;
    if (done) begin
      lv[m_base[6:3]] = !(m_kill || inv);
      lt[m_base[6:3]] = m_base[31:7];
      m_busy = 0;
    end else if (was_busy && inv) begin
      m_kill = 1;
    end
    m_addr = a;
    m_vld  = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit exp_miss = m_busy ? 1'b1 : (m_vld && !m_hit(m_addr));
    chk("model_miss", 32'(p_cache_miss), 32'(exp_miss));
    chk("model_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) chk("model_mem_addr", mem_addr, m_base);
    if (!exp_miss && m_vld) chk("model_data", 32'(prg_data), 32'(fw(m_addr)));
  endtask

  // One cycle: drive inputs, clock edge, update model, check #1 later.
  task automatic step(input logic [31:0] a, input bit inv, input bit dv);
    prg_address    = a;
    invalidate     = inv;
    mem_data_valid = dv;
    mem_data       = m_busy ? fw(m_base + 32'(m_cnt)) : 16'(($urandom));
    @(posedge clk);
    model_edge(a, inv, dv);
    #1;
    check_model();
  endtask

  // Hold address a until the miss clears; mode 0 back-to-back, 1 alternate.
  task automatic run_fill(input logic [31:0] a, input int mode,
                          output int cycles, output int words);
    bit tog = 0;
    bit dv;
    cycles = 0; words = 0;
    for (int i = 0; i < 100; i++) begin
      tog = ~tog;
      dv  = m_busy && ((mode == 0) || tog);
      if (mem_req && dv) words++;
      step(a, 1'b0, dv);
      cycles++;
      if (!p_cache_miss) break;
    end
    chk("fill_completes", 32'(p_cache_miss), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [15:0] data;
    bit          chk_data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cyc, wrd;
    logic [31:0] ra;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{addr: 32'(i), miss: 1'b0, data: 16'h1000 + 16'(i), chk_data: 1'b1};
    vecs[8] = '{addr: 32'h8, miss: 1'b1, data: 16'h0, chk_data: 1'b0};

    // Reset values, then first fill of line 0 with back-to-back words.
    do_reset();
    chk("rst_miss", 32'(p_cache_miss), 32'd0);
    chk("rst_data", 32'(prg_data), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    step(32'h0, 1'b0, 1'b0);
    chk("t1_miss_after_sample", 32'(p_cache_miss), 32'd1);
    step(32'h0, 1'b0, 1'b0);
    chk("t1_req_rise", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    run_fill(32'h0, 0, cyc, wrd);
    chk("t1_miss_fall_cycle", 32'(cyc + 2), 32'd10);
    chk("t1_data", 32'(prg_data), 32'h1000);

    // Table sweep over the filled line, then a cold neighbouring line.
    foreach (vecs[i]) begin
      step(vecs[i].addr, 1'b0, 1'b0);
      chk("tbl_miss", 32'(p_cache_miss), 32'(vecs[i].miss));
      if (vecs[i].chk_data) chk("tbl_data", 32'(prg_data), 32'(vecs[i].data));
    end
    run_fill(32'h8, 0, cyc, wrd);

    // Conflict on index 0 with a different tag.
    step(32'h83, 1'b0, 1'b0);
    chk("t3_miss", 32'(p_cache_miss), 32'd1);
    step(32'h83, 1'b0, 1'b0);
    chk("t3_req", 32'(mem_req), 32'd1);
    chk("t3_mem_addr", mem_addr, 32'h80);
    run_fill(32'h83, 0, cyc, wrd);
    chk("t3_data", 32'(prg_data), 32'h1083);
    step(32'h0, 1'b0, 1'b0);
    chk("t3_evicted_miss", 32'(p_cache_miss), 32'd1);
    run_fill(32'h0, 0, cyc, wrd);

    // Alternate-cycle data valid.
    run_fill(32'h20, 1, cyc, wrd);
    chk("t4_words", 32'(wrd), 32'd8);
    chk("t4_req_low", 32'(mem_req), 32'd0);
    chk("t4_data", 32'(prg_data), 32'(fw(32'h20)));

    // Invalidate during the fill of 0x10: burst completes, line stays invalid.
    step(32'h10, 1'b0, 1'b0);
    step(32'h10, 1'b0, 1'b0);
    for (int w = 0; w < 8; w++) step(32'h10, (w == 3), 1'b1);
    chk("t5_recheck_miss", 32'(p_cache_miss), 32'd1);
    chk("t5_req_low", 32'(mem_req), 32'd0);
    step(32'h10, 1'b0, 1'b0);
    chk("t5_refill_req", 32'(mem_req), 32'd1);
    chk("t5_refill_addr", mem_addr, 32'h10);
    run_fill(32'h10, 0, cyc, wrd);
    chk("t5_data", 32'(prg_data), 32'(fw(32'h10)));

    // Invalidate while idle.
    run_fill(32'h0, 0, cyc, wrd);
    step(32'h0, 1'b0, 1'b0);
    chk("t5_idle_hit", 32'(p_cache_miss), 32'd0);
    step(32'h0, 1'b1, 1'b0);
    chk("t5_idle_inv_miss", 32'(p_cache_miss), 32'd1);
    run_fill(32'h0, 0, cyc, wrd);

    // Reset asserted while the 4th fill word is presented.
    step(32'h40, 1'b0, 1'b0);
    step(32'h40, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) step(32'h40, 1'b0, 1'b1);
    mem_data_valid = 1'b1;
    mem_data       = fw(32'h43);
    #2 rst = 1'b0;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_miss_rst", 32'(p_cache_miss), 32'd0);
    chk("t6_data_rst", 32'(prg_data), 32'd0);
    model_reset();
    mem_data_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    step(32'h0, 1'b0, 1'b0);
    chk("t6_zero_miss", 32'(p_cache_miss), 32'd1);
    run_fill(32'h0, 0, cyc, wrd);
    step(32'h10, 1'b0, 1'b0);
    chk("t6_line2_invalid", 32'(p_cache_miss), 32'd1);
    run_fill(32'h10, 0, cyc, wrd);

    // Randomized traffic against the model.
    ra = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      if (!p_cache_miss || $urandom_range(0, 9) == 0) begin
        ra = 32'($urandom_range(0, 511));
        if ($urandom_range(0, 15) == 0) ra[31:16] = 16'($urandom);
      end
      step(ra, ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prg_cache.md
# prg_cache

Direct-mapped, read-only program cache between the PC stage and the SDRAM burst controller. It accepts the fetch address every cycle, returns the instruction word one cycle later, and raises `p_cache_miss` (consumed by the PC stage) while the requested line is absent or being filled. On a miss it fetches one full line through a request/burst handshake and writes it into the arrays. The PC holds the miss address until `p_cache_miss` drops.

## Interface
- `INDEX_BITS`, default 4: line index width; the cache holds 2^INDEX_BITS lines.
- `OFFSET_BITS`, default 3: word-in-line width; a line is 2^OFFSET_BITS words.
- `DATA_W`, default 16: instruction word width.
- Derived: `TAG_BITS` = 32 − INDEX_BITS − OFFSET_BITS.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `prg_address`  in  32  fetch word address, sampled every cycle.
- `invalidate`  in  1  one-cycle pulse that clears all valid bits.
- `prg_data`  out  DATA_W  instruction word for the address sampled on the previous edge.
- `p_cache_miss`  out  1  `prg_data` is not valid this cycle.
- `mem_req`  out  1  line-fill request, held high until the last word is accepted.
- `mem_addr`  out  32  line base address, `{tag, index, OFFSET_BITS'b0}`, stable while `mem_req` is high.
- `mem_data`  in  DATA_W  fill word.
- `mem_data_valid`  in  1  `mem_data` is valid; words arrive in offset order 0 to 2^OFFSET_BITS−1.

## Operation
- Storage: per line, one valid bit, one tag register and 2^OFFSET_BITS data words. Arrays are built from registers.
- Every edge captures `addr_q` ← `prg_address` and sets `addr_vld` ← 1.
- `hit` = `addr_vld` & valid[idx(addr_q)] & (tag[idx(addr_q)] == tag(addr_q)).
- `prg_data` = data[idx(addr_q)][off(addr_q)], read combinationally from `addr_q`.
- State machine:
  - IDLE: `p_cache_miss` = `addr_vld` & ~hit. On a miss, at the next edge: latch the fill tag and index from `addr_q`, set `mem_req`=1, drive `mem_addr` from the latched values, clear `fill_cnt`, clear `kill`, go to FILL.
  - FILL: `p_cache_miss`=1. Each `mem_data_valid` writes `mem_data` to data[fill_idx][fill_cnt] and increments `fill_cnt`.
  - Last word of FILL (`fill_cnt` = all ones): write tag[fill_idx]; set valid[fill_idx] = ~kill; clear `mem_req`; go to IDLE.
- `mem_data_valid` outside FILL is ignored.
- `invalidate`: clears every valid bit at the edge. If it arrives during FILL, it also sets `kill`, so the line being filled finishes its burst but stays invalid. If `invalidate` coincides with the last fill word, the line stays invalid.
- A fill overwrites any previous contents of its line. There is no victim writeback because the cache is read-only.
- After returning to IDLE, the held address is re-checked. It normally hits. If it still misses (killed fill, or the address changed), a new fill starts.

## Timing
- Hit latency: address at edge N gives `prg_data` and `p_cache_miss`=0 in cycle N+1.
- Miss: `p_cache_miss`=1 in cycle N+1, and `mem_req` rises at edge N+1.
- Fill: `p_cache_miss` stays 1 until the edge that accepts the last word. In the following cycle the re-sampled address hits, giving `p_cache_miss`=0 with valid data.
- Minimum miss penalty is 2 + 2^OFFSET_BITS cycles (10 at defaults), assuming back-to-back `mem_data_valid`.
- `mem_data_valid` may be asserted in the same cycle `mem_req` rises; the data is accepted.
- Reset values: `p_cache_miss`=0, `prg_data`=0, `mem_req`=0, `mem_addr`=0. Also cleared: all valid bits, `addr_vld`, `kill`, `fill_cnt`; state = IDLE.
- Reset during FILL: the fill is abandoned immediately. The memory side must tolerate `mem_req` dropping mid-burst.
- Index and offset arithmetic wraps naturally. `fill_cnt` is OFFSET_BITS wide.

## Test plan
- Reset, then address 0x00000000 held. Required: `p_cache_miss` 0 in the first cycle after reset, then 1. `mem_req` rises with `mem_addr`=0x0. Feed words 0x1000..0x1007 back-to-back. Required: `p_cache_miss` falls on cycle 10 and `prg_data`=0x1000.
- After that fill, sweep addresses 0x0..0x7 on consecutive cycles. Required: no miss, `prg_data` = 0x1000..0x1007 each one cycle late.
- Address 0x00000083 (same index 0, different tag). Required: miss, `mem_addr`=0x00000080. After the fill, 0x0 misses again (conflict eviction).
- Fill with `mem_data_valid` asserted on alternate cycles. Required: `mem_req` stays high and `mem_addr` stays stable through 8 accepted words, then `mem_req` deasserts.
- Pulse `invalidate` mid-fill of 0x10. Required: the burst completes and the re-check misses, starting a second fill to 0x10. Separately, `invalidate` while idle makes a previously hitting 0x0 miss.
- Assert reset (low) on the 4th fill word. Required: `mem_req`=0 immediately, no line valid after release, and 0x0 misses.
